sram_responder: RTL and testbench

- Memory-side responder for the control unit's SRAM request interface: active-low enable `sram_en` and a read/write select `write_en` (0 = write, 1 = read), with an 8-bit address and a 16-bit data word.
- Holds a 256 x 16 storage array and serves CU fetch, LOAD and STORE cycles with registered read data and a configurable number of wait states.
- Provides a preload port so a bench or boot loader can fill program memory while the CU is held in reset.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/sram_array.sv | 55 +++++
 rtl/sram_responder.sv | 137 +++++++++++++
 tb/tb_sram_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Constants shared by the control unit and its SRAM responder: bus
// encodings, default widths and the responder state encoding.
package cpu_pkg;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 16;
  localparam int WAIT_CNT_W = 4;

  localparam logic MEM_WRITE   = 1'b0;
  localparam logic MEM_READ    = 1'b1;
  localparam logic MEM_ENABLE  = 1'b0;
  localparam logic MEM_DISABLE = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } resp_state_e;

endpackage

// File: rtl/sram_array.sv
// Single-port storage with a write-port mux between the CU access path and
// the preload path, plus the registered read-data output.
module sram_array
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_we,
  input  logic              acc_re,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  input  logic              pre_we,
  input  logic [ADDR_W-1:0] pre_addr,
  input  logic [DATA_W-1:0] pre_wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // The responder never asserts both write sources in one cycle; access wins anyway.
  always_comb begin
    wr_en   = acc_we | pre_we;
    wr_addr = acc_we ? acc_addr  : pre_addr;
    wr_data = acc_we ? acc_wdata : pre_wdata;
    rdata_d = acc_re ? mem[acc_addr] : rdata_q;
  end

  // Storage is deliberately left out of reset so it maps onto a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the CU SRAM interface: request FSM, wait-state
// counter and busy detection around a 2**ADDR_W x DATA_W array.
module sram_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = CPU_ADDR_W,
  parameter int DATA_W      = CPU_DATA_W,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sram_en,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] adress,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              ready,
  input  logic              preload_en,
  input  logic [ADDR_W-1:0] preload_addr,
  input  logic [DATA_W-1:0] preload_data,
  output logic              busy_err
);

  // Counter holds remaining WAIT cycles; the access fires when it reads zero.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  resp_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  busy_err_q, busy_err_d;
  logic                  rdata_valid_q, rdata_valid_d;
  logic [ADDR_W-1:0]     cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]     cap_wdata_q, cap_wdata_d;
  logic                  cap_read_q, cap_read_d;

  logic                  req;
  logic                  acc_go;
  logic                  acc_read;
  logic [ADDR_W-1:0]     acc_addr;
  logic [DATA_W-1:0]     acc_wdata;
  logic                  pre_go;

  // Gating with reset keeps a request from writing the array while held in reset.
  assign req = (sram_en == MEM_ENABLE) && !reset;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    busy_err_d    = busy_err_q;
    cap_addr_d    = cap_addr_q;
    cap_wdata_d   = cap_wdata_q;
    cap_read_d    = cap_read_q;
    acc_go        = 1'b0;
    acc_read      = cap_read_q;
    acc_addr      = cap_addr_q;
    acc_wdata     = cap_wdata_q;
    pre_go        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            acc_go    = 1'b1;
            acc_read  = (write_en == MEM_READ);
            acc_addr  = adress;
            acc_wdata = wdata;
          end else begin
            cnt_d       = WAIT_LOAD;
            cap_addr_d  = adress;
            cap_wdata_d = wdata;
            cap_read_d  = (write_en == MEM_READ);
            state_d     = ST_WAIT;
          end
        end else if (preload_en) begin
          pre_go = 1'b1;
        end
      end
      ST_WAIT: begin
        if (req) begin
          busy_err_d = 1'b1;
        end
        if (cnt_q == '0) begin
          acc_go  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rdata_valid_d = acc_go & acc_read;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      busy_err_q    <= 1'b0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_err_q    <= busy_err_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  // Captured request fields are pure data and need no reset.
  always_ff @(posedge clk) begin
    cap_addr_q  <= cap_addr_d;
    cap_wdata_q <= cap_wdata_d;
    cap_read_q  <= cap_read_d;
  end

  sram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .acc_we    (acc_go & ~acc_read),
    .acc_re    (acc_go & acc_read),
    .acc_addr  (acc_addr),
    .acc_wdata (acc_wdata),
    .pre_we    (pre_go),
    .pre_addr  (preload_addr),
    .pre_wdata (preload_data),
    .rdata     (rdata)
  );

  assign rdata_valid = rdata_valid_q;
  assign ready       = (state_q == ST_IDLE);
  assign busy_err    = busy_err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: three instances (0, 3 and 2 wait states)
// share stimulus; read data is checked against a per-instance scoreboard.
module tb_sram_responder;

  logic        clk;
  logic        reset;
  logic        en0, en3, en2;
  logic        write_en;
  logic [7:0]  adress;
  logic [15:0] wdata;
  logic        preload_en;
  logic [7:0]  preload_addr;
  logic [15:0] preload_data;

  logic [15:0] rd0, rd3, rd2;
  logic        rv0, rv3, rv2;
  logic        rdy0, rdy3, rdy2;
  logic        be0, be3, be2;

  logic [15:0] q0[$];
  logic [15:0] q3[$];
  logic [15:0] q2[$];
  logic [15:0] e0, e3, e2;
  logic [15:0] gpr;

  int checks   = 0;
  int failures = 0;

  sram_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .sram_en(en0), .write_en(write_en), .adress(adress),
    .wdata(wdata), .rdata(rd0), .rdata_valid(rv0), .ready(rdy0),
    .preload_en(preload_en), .preload_addr(preload_addr), .preload_data(preload_data),
    .busy_err(be0));

  sram_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(3)) u3 (
    .clk(clk), .reset(reset), .sram_en(en3), .write_en(write_en), .adress(adress),
    .wdata(wdata), .rdata(rd3), .rdata_valid(rv3), .ready(rdy3),
    .preload_en(preload_en), .preload_addr(preload_addr), .preload_data(preload_data),
    .busy_err(be3));

  sram_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(2)) u2 (
    .clk(clk), .reset(reset), .sram_en(en2), .write_en(write_en), .adress(adress),
    .wdata(wdata), .rdata(rd2), .rdata_valid(rv2), .ready(rdy2),
    .preload_en(preload_en), .preload_addr(preload_addr), .preload_data(preload_data),
    .busy_err(be2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Scoreboard: every rdata_valid pulse must match the oldest pending read.
  always @(negedge clk) begin
    if (rv0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $error("FAIL sb_u0_unexpected observed=%h expected=none", rd0);
      end else begin
        e0 = q0.pop_front();
        assert (rd0 === e0) else begin
          failures++;
          $error("FAIL sb_u0_rdata observed=%h expected=%h", rd0, e0);
        end
      end
    end
    if (rv3) begin
      checks++;
      if (q3.size() == 0) begin
        failures++;
        $error("FAIL sb_u3_unexpected observed=%h expected=none", rd3);
      end else begin
        e3 = q3.pop_front();
        assert (rd3 === e3) else begin
          failures++;
          $error("FAIL sb_u3_rdata observed=%h expected=%h", rd3, e3);
        end
      end
    end
    if (rv2) begin
      checks++;
      if (q2.size() == 0) begin
        failures++;
        $error("FAIL sb_u2_unexpected observed=%h expected=none", rd2);
      end else begin
        e2 = q2.pop_front();
        assert (rd2 === e2) else begin
          failures++;
          $error("FAIL sb_u2_rdata observed=%h expected=%h", rd2, e2);
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    en0          = 1'b1;
    en3          = 1'b1;
    en2          = 1'b1;
    write_en     = 1'b1;
    adress       = 8'h00;
    wdata        = 16'h0000;
    preload_en   = 1'b0;
    preload_addr = 8'h00;
    preload_data = 16'h0000;
    gpr          = 16'h0000;

    cyc(2);
    chk("reset_rdata",    rd0,          16'h0000);
    chk("reset_valid",    {15'd0, rv0}, 16'd0);
    chk("reset_ready",    {15'd0, rdy0}, 16'd1);
    chk("reset_busy_err", {15'd0, be0}, 16'd0);
    chk("reset_ready_u3", {15'd0, rdy3}, 16'd1);

    // Preload while held in reset
    preload_en = 1'b1;
    preload_addr = 8'h00; preload_data = 16'h1A05; cyc(1);
    preload_addr = 8'h05; preload_data = 16'hBEEF; cyc(1);
    preload_addr = 8'h10; preload_data = 16'h5555; cyc(1);
    preload_en = 1'b0;
    reset = 1'b0;
    cyc(1);

    // Preload then read, 0 wait states
    en0 = 1'b0; write_en = 1'b1; adress = 8'h05; q0.push_back(16'hBEEF);
    cyc(1);
    en0 = 1'b1;
    chk("pr_valid_pulse", {15'd0, rv0}, 16'd1);
    cyc(3);
    chk("pr_rdata_hold", rd0, 16'hBEEF);
    chk("pr_valid_low",  {15'd0, rv0}, 16'd0);

    // Write then read; rdata unchanged across the write
    en0 = 1'b0; write_en = 1'b0; adress = 8'h7F; wdata = 16'h1234;
    cyc(1);
    chk("wr_rdata_unchanged", rd0, 16'hBEEF);
    write_en = 1'b1; q0.push_back(16'h1234);
    cyc(1);
    en0 = 1'b1;
    chk("wr_rd_rdata", rd0, 16'h1234);

    // Wait states = 3
    en3 = 1'b0; write_en = 1'b1; adress = 8'h05; q3.push_back(16'hBEEF);
    cyc(1);
    en3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ws3_ready_low", {15'd0, rdy3}, 16'd0);
      if (i < 2) cyc(1);
    end
    chk("ws3_rdata_early", rd3, 16'h0000);
    cyc(1);
    chk("ws3_ready_back", {15'd0, rdy3}, 16'd1);
    chk("ws3_valid",      {15'd0, rv3},  16'd1);

    // Busy error with wait states = 2
    en2 = 1'b0; write_en = 1'b1; adress = 8'h05; q2.push_back(16'hBEEF);
    cyc(1);
    adress = 8'h00;
    cyc(1);
    en2 = 1'b1;
    chk("busy_err_set",  {15'd0, be2},  16'd1);
    chk("busy_ready_lo", {15'd0, rdy2}, 16'd0);
    cyc(1);
    chk("busy_first_done", rd2, 16'hBEEF);
    cyc(3);
    chk("busy_err_sticky", {15'd0, be2}, 16'd1);
    chk("busy_no_second",  rd2, 16'hBEEF);

    // Collision: request beats preload
    en0 = 1'b0; write_en = 1'b1; adress = 8'h00; q0.push_back(16'h1A05);
    preload_en = 1'b1; preload_addr = 8'h00; preload_data = 16'hFFFF;
    cyc(1);
    preload_en = 1'b0;
    q0.push_back(16'h1A05);
    cyc(1);
    en0 = 1'b1;
    chk("coll_rdata", rd0, 16'h1A05);

    // Reset mid-WAIT on a write aborts it
    en3 = 1'b0; write_en = 1'b0; adress = 8'h10; wdata = 16'hABCD;
    cyc(1);
    en3 = 1'b1;
    #2 reset = 1'b1;
    cyc(1);
    chk("abort_rdata",   rd3, 16'h0000);
    chk("abort_ready",   {15'd0, rdy3}, 16'd1);
    chk("abort_busy_clr", {15'd0, be2}, 16'd0);
    reset = 1'b0;
    cyc(1);
    en3 = 1'b1;
    en3 = 1'b0; write_en = 1'b1; adress = 8'h10; q3.push_back(16'h5555);
    cyc(1);
    en3 = 1'b1;
    cyc(3);
    chk("abort_mem_kept", rd3, 16'h5555);

    // Back-to-back accesses and read-after-write
    en0 = 1'b0; write_en = 1'b0;
    adress = 8'h30; wdata = 16'h1111; cyc(1);
    adress = 8'h31; wdata = 16'h2222; cyc(1);
    write_en = 1'b1;
    adress = 8'h30; q0.push_back(16'h1111); cyc(1);
    adress = 8'h31; q0.push_back(16'h2222); cyc(1);
    write_en = 1'b0; adress = 8'hFF; wdata = 16'hAAAA; cyc(1);
    write_en = 1'b1; q0.push_back(16'hAAAA); cyc(1);
    en0 = 1'b1;
    chk("raw_rdata", rd0, 16'hAAAA);

    // CU-style program: fetch, LOAD into a GPR, STORE it, read back
    en0 = 1'b0; write_en = 1'b1; adress = 8'h00; q0.push_back(16'h1A05); cyc(1);
    adress = 8'h05; q0.push_back(16'hBEEF); cyc(1);
    en0 = 1'b1;
    gpr = rd0;
    cyc(1);
    en0 = 1'b0; write_en = 1'b0; adress = 8'h60; wdata = gpr; cyc(1);
    write_en = 1'b1; q0.push_back(16'hBEEF); cyc(1);
    en0 = 1'b1;
    chk("cu_store_readback", rd0, 16'hBEEF);

    cyc(6);
    chk("sb_u0_drained", 16'(q0.size()), 16'd0);
    chk("sb_u3_drained", 16'(q3.size()), 16'd0);
    chk("sb_u2_drained", 16'(q2.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
